// File: rtl/parallax_gps_responder.sv
// Parallax-GPS-style responder on a shared half-duplex serial line.
// Parses "!GPS"+cmd, waits a turnaround, then replies with a snapshot of
// the addressed data field, driving the line only while it talks.

// Minimal 8N1 uart: transmit accepts a new byte on the same clock the
// previous stop bit ends, so consecutive bytes go out with no gap.
module uart #(
   parameter int BAUD   = 4800,
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       txd,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ack,
   output logic [7:0] rx_data,
   output logic       rx_data_valid
);

   localparam int BIT_CLKS = CLK_HZ / BAUD;
   localparam int CW       = $clog2(BIT_CLKS) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bits_q, tx_bits_d;
   logic [8:0]    tx_shift_q, tx_shift_d;
   logic          txd_q, txd_d;
   logic          tx_done;

   logic          rx_busy_q, rx_busy_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bits_q, rx_bits_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;

   // transmit: start bit, 8 data bits LSB first, stop bit
   always_comb begin
      tx_busy_d   = tx_busy_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bits_d   = tx_bits_q;
      tx_shift_d  = tx_shift_q;
      txd_d       = txd_q;
      tx_done     = tx_busy_q && (tx_cnt_q == '0) && (tx_bits_q == 4'd0);
      tx_data_ack = tx_data_valid && (!tx_busy_q || tx_done);
      if (tx_data_ack) begin
         tx_busy_d  = 1'b1;
         tx_shift_d = {1'b1, tx_data};
         tx_bits_d  = 4'd9;
         tx_cnt_d   = BIT_LAST;
         txd_d      = 1'b0;
      end else if (tx_busy_q) begin
         if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
         end else if (tx_bits_q == 4'd0) begin
            tx_busy_d = 1'b0;
         end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bits_d  = tx_bits_q - 4'd1;
            tx_cnt_d   = BIT_LAST;
         end
      end
   end

   // receive: mid-bit sampling, frame dropped on a bad start or stop bit
   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bits_d  = rx_bits_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      if (!rx_busy_q) begin
         if (!rxd) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = HALF_LAST;
            rx_bits_d = 4'd0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 1'b1;
      end else begin
         rx_cnt_d = BIT_LAST;
         if (rx_bits_q == 4'd0) begin
            if (rxd) rx_busy_d = 1'b0;
            else     rx_bits_d = 4'd1;
         end else if (rx_bits_q <= 4'd8) begin
            rx_shift_d = {rxd, rx_shift_q[7:1]};
            rx_bits_d  = rx_bits_q + 4'd1;
         end else begin
            rx_busy_d = 1'b0;
            if (rxd) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
            end
         end
      end
   end

   // uart state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bits_q  <= 4'd0;
         tx_shift_q <= '1;
         txd_q      <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bits_q  <= 4'd0;
         rx_shift_q <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bits_q  <= tx_bits_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_busy_q  <= rx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign txd           = txd_q;
   assign rx_data       = rx_data_q;
   assign rx_data_valid = rx_valid_q;

endmodule

// state    | meaning
// HUNT     | idle, waiting for '!'
// GOT_BANG | seen '!', expecting 'G'
// GOT_G    | seen "!G", expecting 'P'
// GOT_P    | seen "!GP", expecting 'S'
// GOT_S    | seen "!GPS", expecting command byte 0x00-0x09
// TURN     | command accepted, line left to the initiator for its tail
// SEND     | driving line, streaming reply bytes
// DRAIN    | still driving until the last byte plus one idle bit is out
module parallax_gps_responder #(
   parameter int BAUD       = 4800,
   parameter int CLK_HZ     = 50_000_000,
   parameter int TURN_CHARS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_din,
   output logic        s_dout,
   output logic        s_oe,
   input  logic [7:0]  hw_version,
   input  logic [0:0]  info_valid,
   input  logic [3:0]  sats,
   input  logic [23:0] gmt_time,
   input  logic [23:0] gmt_date,
   input  logic [39:0] latitude,
   input  logic [39:0] longitude,
   input  logic [15:0] altitude,
   input  logic [15:0] speed,
   input  logic [15:0] heading,
   output logic [3:0]  last_cmd,
   output logic [15:0] query_count,
   output logic [0:0]  busy
);

   localparam int CHAR_CLKS = 10 * CLK_HZ / BAUD;
   localparam logic [31:0] TIMEOUT_CLKS = 32'(4 * CHAR_CLKS);
   localparam logic [31:0] TURN_CLKS    = 32'(TURN_CHARS * CHAR_CLKS);
   localparam logic [31:0] DRAIN_CLKS   = 32'(CHAR_CLKS + CHAR_CLKS / 10);
   localparam logic [7:0]  BANG = 8'h21;

   typedef enum logic [2:0] {
      HUNT, GOT_BANG, GOT_G, GOT_P, GOT_S, TURN, SEND, DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [39:0] reply_q, reply_d;
   logic [2:0]  count_q, count_d;
   logic [3:0]  last_cmd_q, last_cmd_d;
   logic [15:0] query_count_q, query_count_d;
   logic        s_din_q, s_din_d;
   logic        s_oe_q, s_oe_d;
   logic        s_dout_q, s_dout_d;

   logic        txd, tx_valid, tx_ack, rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  parse_byte;
   state_t      parse_next;

   uart #(.BAUD(BAUD), .CLK_HZ(CLK_HZ)) u_uart (
      .clk           (clk),
      .rst           (rst),
      .rxd           (s_din_q),
      .txd           (txd),
      .tx_data       (reply_q[39:32]),
      .tx_data_valid (tx_valid),
      .tx_data_ack   (tx_ack),
      .rx_data       (rx_data),
      .rx_data_valid (rx_valid)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         timer_q       <= '0;
         reply_q       <= '0;
         count_q       <= 3'd0;
         last_cmd_q    <= 4'd0;
         query_count_q <= 16'd0;
         s_din_q       <= 1'b1;
         s_oe_q        <= 1'b0;
         s_dout_q      <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         reply_q       <= reply_d;
         count_q       <= count_d;
         last_cmd_q    <= last_cmd_d;
         query_count_q <= query_count_d;
         s_din_q       <= s_din_d;
         s_oe_q        <= s_oe_d;
         s_dout_q      <= s_dout_d;
      end
   end

   // next state: header parse, command accept, turnaround and reply sequencing
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      reply_d       = reply_q;
      count_d       = count_q;
      last_cmd_d    = last_cmd_q;
      query_count_d = query_count_q;
      s_din_d       = s_din;
      parse_byte    = 8'h00;
      parse_next    = HUNT;
      case (state_q)
         GOT_BANG: begin parse_byte = 8'h47; parse_next = GOT_G; end
         GOT_G:    begin parse_byte = 8'h50; parse_next = GOT_P; end
         GOT_P:    begin parse_byte = 8'h53; parse_next = GOT_S; end
         default:  ;
      endcase
      case (state_q)
         HUNT: begin
            timer_d = '0;
            if (rx_valid && rx_data == BANG) begin
               state_d = GOT_BANG;
               timer_d = TIMEOUT_CLKS;
            end
         end
         GOT_BANG, GOT_G, GOT_P: begin
            if (rx_valid) begin
               timer_d = TIMEOUT_CLKS;
               if (rx_data == parse_byte) begin
                  state_d = parse_next;
               end else if (rx_data == BANG) begin
                  state_d = GOT_BANG;
               end else begin
                  state_d = HUNT;
                  timer_d = '0;
               end
            end else if (timer_q == 32'd1) begin
               state_d = HUNT;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         GOT_S: begin
            if (rx_valid) begin
               if (rx_data <= 8'h09) begin
                  state_d       = TURN;
                  timer_d       = TURN_CLKS;
                  last_cmd_d    = rx_data[3:0];
                  query_count_d = query_count_q + 16'd1;
                  case (rx_data[3:0])
                     4'd0:    begin reply_d = {hw_version, 32'h0};        count_d = 3'd1; end
                     4'd1:    begin reply_d = {7'h0, info_valid, 32'h0};  count_d = 3'd1; end
                     4'd2:    begin reply_d = {4'h0, sats, 32'h0};        count_d = 3'd1; end
                     4'd3:    begin reply_d = {gmt_time, 16'h0};          count_d = 3'd3; end
                     4'd4:    begin reply_d = {gmt_date, 16'h0};          count_d = 3'd3; end
                     4'd5:    begin reply_d = latitude;                   count_d = 3'd5; end
                     4'd6:    begin reply_d = longitude;                  count_d = 3'd5; end
                     4'd7:    begin reply_d = {altitude, 24'h0};          count_d = 3'd2; end
                     4'd8:    begin reply_d = {speed, 24'h0};             count_d = 3'd2; end
                     default: begin reply_d = {heading, 24'h0};           count_d = 3'd2; end
                  endcase
               end else begin
                  state_d = HUNT;
                  timer_d = '0;
               end
            end else if (timer_q == 32'd1) begin
               state_d = HUNT;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         TURN: begin
            if (timer_q == 32'd1) begin
               state_d = SEND;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         SEND: begin
            if (tx_ack) begin
               reply_d = {reply_q[31:0], 8'h00};
               count_d = count_q - 3'd1;
               if (count_q == 3'd1) begin
                  state_d = DRAIN;
                  timer_d = DRAIN_CLKS;
               end
            end
         end
         DRAIN: begin
            if (timer_q == 32'd1) begin
               state_d = HUNT;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // outputs: line drive only while replying, idle-high otherwise
   always_comb begin
      tx_valid = (state_q == SEND);
      s_oe_d   = (state_q == SEND) || (state_q == DRAIN);
      s_dout_d = s_oe_d ? txd : 1'b1;
      busy     = (state_q != HUNT);
   end

   assign s_dout      = s_dout_q;
   assign s_oe        = s_oe_q;
   assign last_cmd    = last_cmd_q;
   assign query_count = query_count_q;

endmodule

// File: tb/tb_parallax_gps_responder.sv
// Directed bench for parallax_gps_responder on a modelled shared line.
module tb_parallax_gps_responder;

   localparam int BAUD   = 10;
   localparam int CLK_HZ = 160;
   localparam int TURN   = 3;
   localparam int BIT    = CLK_HZ / BAUD;
   localparam int CHAR   = 10 * CLK_HZ / BAUD;

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_line;
   logic        s_din;
   logic        s_dout, s_oe;
   logic [7:0]  hw_version;
   logic [0:0]  info_valid;
   logic [3:0]  sats;
   logic [23:0] gmt_time, gmt_date;
   logic [39:0] latitude, longitude;
   logic [15:0] altitude, speed, heading;
   logic [3:0]  last_cmd;
   logic [15:0] query_count;
   logic [0:0]  busy;

   assign s_din = s_oe ? s_dout : tb_line;

   parallax_gps_responder #(.BAUD(BAUD), .CLK_HZ(CLK_HZ), .TURN_CHARS(TURN)) dut (
      .clk(clk), .rst(rst), .s_din(s_din), .s_dout(s_dout), .s_oe(s_oe),
      .hw_version(hw_version), .info_valid(info_valid), .sats(sats),
      .gmt_time(gmt_time), .gmt_date(gmt_date), .latitude(latitude),
      .longitude(longitude), .altitude(altitude), .speed(speed), .heading(heading),
      .last_cmd(last_cmd), .query_count(query_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // line monitor: decodes bytes driven by the DUT
   logic [7:0] mon_q[$];
   int         mon_start_q[$];
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (s_oe === 1'b1 && s_dout === 1'b0) begin
            mon_start_q.push_back(cyc);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = s_dout;
            end
            repeat (BIT) @(negedge clk);
            mon_q.push_back(b);
         end
      end
   end

   int   oe_rises = 0;
   int   oe_rise_cyc = 0;
   int   oe_fall_cyc = 0;
   logic oe_prev = 1'b0;
   always @(negedge clk) begin
      if (s_oe && !oe_prev) begin
         oe_rises    = oe_rises + 1;
         oe_rise_cyc = cyc;
      end
      if (!s_oe && oe_prev) oe_fall_cyc = cyc;
      oe_prev = s_oe;
   end

   int mon_base, oe_base, cmd_start_cyc;

   task automatic arm();
      mon_base = mon_q.size();
      oe_base  = oe_rises;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         tb_line = fr[i];
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic send_cmd(input logic [7:0] c);
      send_byte(8'h21);
      send_byte(8'h47);
      send_byte(8'h50);
      send_byte(8'h53);
      cmd_start_cyc = cyc;
      send_byte(c);
   endtask

   task automatic finish_query(input string tag, input int n_exp, input logic [39:0] exp,
                               input int exp_cnt, input int exp_last);
      int t;
      int got;
      logic [39:0] e;
      repeat (8) @(negedge clk);
      check({tag, " busy_after_cmd"}, longint'(busy), (n_exp > 0) ? 1 : 0);
      t = 0;
      while (busy && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check({tag, " back_to_hunt"}, longint'(busy), 0);
      repeat (20) @(negedge clk);
      got = mon_q.size() - mon_base;
      check({tag, " byte_count"}, got, n_exp);
      e = exp;
      for (int i = 0; i < n_exp && i < got; i++) begin
         check($sformatf("%s byte%0d", tag, i), longint'(mon_q[mon_base + i]), longint'(e[39:32]));
         e = e << 8;
      end
      check({tag, " oe_rises"}, oe_rises - oe_base, (n_exp > 0) ? 1 : 0);
      if (n_exp > 0 && got > 0) begin
         check({tag, " oe_high_clks"}, oe_fall_cyc - oe_rise_cyc, CHAR * (n_exp - 1) + CHAR + CHAR / 10 + 1);
         check_range({tag, " turn_latency"}, mon_start_q[mon_base] - cmd_start_cyc,
                     9 * BIT + BIT / 2 + TURN * CHAR - 2, 9 * BIT + BIT / 2 + TURN * CHAR + 12);
      end
      check({tag, " query_count"}, longint'(query_count), exp_cnt);
      check({tag, " last_cmd"}, longint'(last_cmd), exp_last);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      int          n;
      logic [39:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vecs[0] = '{8'h00, 1, 40'h12_0000_0000};
      vecs[1] = '{8'h01, 1, 40'h01_0000_0000};
      vecs[2] = '{8'h02, 1, 40'h0A_0000_0000};
      vecs[3] = '{8'h03, 3, 40'h0C_2233_0000};
      vecs[4] = '{8'h04, 3, 40'h07_1519_0000};
      vecs[5] = '{8'h05, 5, 40'h2A_1F3C_4D01};
      vecs[6] = '{8'h06, 5, 40'h7B_0E2F_1157};
      vecs[7] = '{8'h07, 2, 40'h13_8800_0000};
      vecs[8] = '{8'h08, 2, 40'h00_FF00_0000};
      vecs[9] = '{8'h09, 2, 40'h0D_0500_0000};

      hw_version = 8'h12;  info_valid = 1'b1;      sats = 4'hA;
      gmt_time   = 24'h0C2233; gmt_date = 24'h071519;
      latitude   = 40'h2A1F3C4D01; longitude = 40'h7B0E2F1157;
      altitude   = 16'h1388; speed = 16'h00FF; heading = 16'h0D05;
      tb_line    = 1'b1;
      rst        = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset s_oe", longint'(s_oe), 0);
      check("reset s_dout", longint'(s_dout), 1);
      check("reset last_cmd", longint'(last_cmd), 0);
      check("reset query_count", longint'(query_count), 0);
      check("reset busy", longint'(busy), 0);
      repeat (BIT) @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         arm();
         send_cmd(vecs[v].cmd);
         finish_query($sformatf("cmd%0d", v), vecs[v].n, vecs[v].exp, v + 1, int'(vecs[v].cmd));
      end

      arm();
      send_cmd(8'h0A);
      finish_query("bad_cmd_0A", 0, 40'h0, 10, 9);

      arm();
      send_byte(8'h21); send_byte(8'h47); send_byte(8'h58); send_byte(8'h53);
      send_byte(8'h01);
      finish_query("bad_hdr_GXS", 0, 40'h0, 10, 9);

      arm();
      send_byte(8'h21); send_byte(8'h47); send_byte(8'h50);
      send_cmd(8'h09);
      finish_query("restart_bang", 2, 40'h0D_0500_0000, 11, 9);

      arm();
      send_byte(8'h21); send_byte(8'h47); send_byte(8'h50);
      repeat (5 * CHAR) @(negedge clk);
      check("timeout busy", longint'(busy), 0);
      send_byte(8'h53); send_byte(8'h01);
      finish_query("timeout", 0, 40'h0, 11, 9);

      arm();
      send_cmd(8'h07);
      altitude = 16'hFFFF;
      finish_query("snapshot", 2, 40'h13_8800_0000, 12, 7);
      altitude = 16'h1388;

      arm();
      send_cmd(8'h03);
      t = 0;
      while (mon_q.size() < mon_base + 1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid first byte", longint'(mon_q.size() - mon_base), 1);
      t = 0;
      while (s_dout !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid second start", longint'(s_dout), 0);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid s_oe", longint'(s_oe), 0);
      check("rst_mid s_dout", longint'(s_dout), 1);
      check("rst_mid busy", longint'(busy), 0);
      check("rst_mid query_count", longint'(query_count), 0);
      rst = 1'b0;
      repeat (400) @(negedge clk);

      sats = 4'h7;
      arm();
      send_cmd(8'h02);
      finish_query("after_rst", 1, 40'h07_0000_0000, 1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
